uart_fifo_drain_ctrl: RTL and testbench
=======================================

Name: uart_fifo_drain_ctrl

Overview:
Read-side sequencer for the UART byte FIFO. It pops bytes from the FIFO and hands them one at a time to the UART transmitter, accounting for the FIFO's one-cycle registered read. It also honours CTS flow control, inserts an optional inter-byte gap, and provides a host-commanded flush. It sits between the TX-path FIFO read port and the UART transmitter.

Parameters:
CTS_ENABLE, 1, 1 = cts_n gates the start of each byte; 0 = cts_n ignored
INTER_BYTE_GAP, 0, idle cycles inserted after each byte completes (0..65535)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = drain FIFO to transmitter
flush  input  1  single-cycle request to discard all FIFO contents
cts_n  input  1  clear-to-send, active low
fifo_empty  input  1  FIFO empty flag
fifo_read_data  input  8  FIFO head byte (registered; valid 1 cycle after pointer change)
fifo_read_strobe  output  1  FIFO pop, one-cycle pulse
tx_ready  input  1  transmitter idle; drops the cycle after tx_start, rises when the byte is done
tx_start  output  1  one-cycle start pulse to transmitter
tx_byte  output  8  byte to transmit, stable from tx_start until the next load
busy  output  1  state != IDLE
bytes_sent  output  32  bytes handed to transmitter, wraps
bytes_flushed  output  32  bytes discarded by flush, wraps

Behaviour:
- Reset (async, immediate): state=IDLE. fifo_read_strobe=0, tx_start=0, tx_byte=0, busy=0, bytes_sent=0, bytes_flushed=0, flush_pending=0, gap counter=0.
- flush is latched into flush_pending in any state. It is cleared on entry to FLUSH_RD.
- fifo_read_strobe, tx_start and busy are Moore decodes of the state register.
- States:
  - IDLE: if flush_pending -> FLUSH_CHK. Else if enable && !fifo_empty && tx_ready && (cts_n==0 || CTS_ENABLE==0) -> SETTLE. Flush has priority.
  - SETTLE: 1 cycle, guarantees fifo_read_data reflects the current out pointer -> LOAD.
  - LOAD: fifo_read_strobe=1; tx_byte<=fifo_read_data -> SEND.
  - SEND: tx_start=1; bytes_sent+=1 -> WAIT_TX.
  - WAIT_TX: hold until tx_ready==1. Then -> GAP (counter loaded with INTER_BYTE_GAP) if INTER_BYTE_GAP>0, else -> IDLE.
  - GAP: decrement each cycle; -> IDLE when counter reaches 1.
  - FLUSH_CHK: if fifo_empty -> IDLE, else -> FLUSH_RD.
  - FLUSH_RD: fifo_read_strobe=1; bytes_flushed+=1 -> FLUSH_WAIT.
  - FLUSH_WAIT: 1 cycle for the FIFO count/empty to update -> FLUSH_CHK. Maximum pop rate during flush is one per 3 cycles, so no underflow from a stale empty flag.
- Timing from the cycle C0 in which the IDLE start condition is sampled true:
  - C1 SETTLE.
  - C2 LOAD (strobe high).
  - C3 SEND (tx_start high, tx_byte valid).
  - C4 onward WAIT_TX.
  - Back-to-back throughput with GAP=0 and an immediate transmitter is 5 cycles per byte plus transmitter time.
- Mid-byte conditions:
  - enable, cts_n and fifo_empty are sampled only in IDLE.
  - Deasserting enable or raising cts_n mid-byte lets the current byte complete.
  - A flush during a byte takes effect after the byte (and gap) finishes.
- Writes to the FIFO are never blocked. A FIFO overflow while the controller waits is outside this block's scope.
- The controller never strobes an empty FIFO. Every strobe is preceded by a fifo_empty==0 sample taken at least one cycle after the previous strobe's effect.
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.
- Reset asserted mid-operation aborts immediately. A pending tx_start or strobe is not issued. The FIFO shares rst.

Test Plan:
- Reset, then write 0x41,0x42,0x43 into the FIFO, enable=1, model transmitter busy 10 cycles -> tx_byte sequence 0x41,0x42,0x43; exactly 3 strobes; bytes_sent=3; fifo_empty=1; busy=0 at end.
- Single byte 0x55, measure cycles -> strobe 2 cycles after the start condition, tx_start 3 cycles after; with INTER_BYTE_GAP=4, the next start condition is not accepted until 4 cycles after tx_ready rises.
- CTS_ENABLE=1, cts_n=1, FIFO holding 2 bytes -> no strobe or tx_start for 50 cycles. Drop cts_n -> both bytes sent. Raise cts_n during byte 1's WAIT_TX -> byte 1 completes and byte 2 is held.
- FIFO holding 5 bytes, pulse flush while byte 0 is in WAIT_TX -> byte 0 completes; 4 strobes at 3-cycle spacing; bytes_flushed=4; no FIFO underflow pulse; then IDLE.
- Assert rst in LOAD and in FLUSH_RD -> all outputs return to reset values the same cycle, with no further strobes.
- Preload bytes_sent near wrap via 2^32-1 sends (force), send 1 more -> bytes_sent=0.

Source files
------------

// File: rtl/uart_fifo_drain_ctrl.sv
// Read-side sequencer for the UART TX byte FIFO: pops one byte at a time into the
// transmitter, with CTS gating, an optional inter-byte gap and a host-commanded flush.
module uart_fifo_drain_ctrl #(
  parameter bit          CTS_ENABLE     = 1'b1,
  parameter int unsigned INTER_BYTE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        cts_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_read_data,
  output logic        fifo_read_strobe,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [31:0] bytes_sent,
  output logic [31:0] bytes_flushed
);

  typedef enum logic [3:0] {
    IDLE,
    SETTLE,
    LOAD,
    SEND,
    WAIT_TX,
    GAP,
    FLUSH_CHK,
    FLUSH_RD,
    FLUSH_WAIT
  } state_t;

  localparam logic [15:0] GAP_LOAD = 16'(INTER_BYTE_GAP);
  localparam bit          GAP_EN   = (INTER_BYTE_GAP != 0);

  state_t      state;
  logic        flush_pending;
  logic [15:0] gap_count;
  logic        cts_ok;

  assign cts_ok = !CTS_ENABLE || !cts_n;

  // Strobe, start and busy decode straight from the state register, so a reset
  // drops them in the same cycle it is asserted.
  assign fifo_read_strobe = (state == LOAD) || (state == FLUSH_RD);
  assign tx_start         = (state == SEND);
  assign busy             = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every branch below
  // sees the values from the start of the cycle, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      gap_count     <= '0;
      tx_byte       <= '0;
      bytes_sent    <= '0;
      bytes_flushed <= '0;
    end else begin
      // A new flush request arriving on the same edge as FLUSH_RD entry must survive.
      if (flush) begin
        flush_pending <= 1'b1;
      end else if (state == FLUSH_CHK && !fifo_empty) begin
        flush_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (flush_pending) begin
            state <= FLUSH_CHK;
          end else if (enable && !fifo_empty && tx_ready && cts_ok) begin
            state <= SETTLE;
          end
        end
        SETTLE: state <= LOAD;
        LOAD: begin
          tx_byte <= fifo_read_data;
          state   <= SEND;
        end
        SEND: begin
          bytes_sent <= bytes_sent + 32'd1;
          state      <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_ready) begin
            if (GAP_EN) begin
              gap_count <= GAP_LOAD;
              state     <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_count <= 16'd1) begin
            gap_count <= '0;
            state     <= IDLE;
          end else begin
            gap_count <= gap_count - 16'd1;
          end
        end
        FLUSH_CHK: state <= fifo_empty ? IDLE : FLUSH_RD;
        FLUSH_RD: begin
          bytes_flushed <= bytes_flushed + 32'd1;
          state         <= FLUSH_WAIT;
        end
        // The FIFO empty flag lags the pop by a cycle; re-check only after it settles.
        FLUSH_WAIT: state <= FLUSH_CHK;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_drain_ctrl.sv
// Directed bench for uart_fifo_drain_ctrl: two instances (no gap / 4-cycle gap), each
// with a registered-read FIFO model and a transmitter model; sent bytes go through a scoreboard.
module tb_uart_fifo_drain_ctrl;
  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NL-1:0]       enable;
  logic                flush;
  logic                cts_n;
  logic [NL-1:0]       fifo_empty;
  logic [NL-1:0][7:0]  fifo_read_data;
  logic [NL-1:0]       fifo_read_strobe;
  logic [NL-1:0]       tx_ready;
  logic [NL-1:0]       tx_start;
  logic [NL-1:0][7:0]  tx_byte;
  logic [NL-1:0]       busy;
  logic [NL-1:0][31:0] bytes_sent;
  logic [NL-1:0][31:0] bytes_flushed;

  uart_fifo_drain_ctrl #(.CTS_ENABLE(1'b1), .INTER_BYTE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable[0]), .flush(flush), .cts_n(cts_n),
    .fifo_empty(fifo_empty[0]), .fifo_read_data(fifo_read_data[0]),
    .fifo_read_strobe(fifo_read_strobe[0]), .tx_ready(tx_ready[0]),
    .tx_start(tx_start[0]), .tx_byte(tx_byte[0]), .busy(busy[0]),
    .bytes_sent(bytes_sent[0]), .bytes_flushed(bytes_flushed[0])
  );

  uart_fifo_drain_ctrl #(.CTS_ENABLE(1'b1), .INTER_BYTE_GAP(4)) dut1 (
    .clk(clk), .rst(rst), .enable(enable[1]), .flush(flush), .cts_n(cts_n),
    .fifo_empty(fifo_empty[1]), .fifo_read_data(fifo_read_data[1]),
    .fifo_read_strobe(fifo_read_strobe[1]), .tx_ready(tx_ready[1]),
    .tx_start(tx_start[1]), .tx_byte(tx_byte[1]), .busy(busy[1]),
    .bytes_sent(bytes_sent[1]), .bytes_flushed(bytes_flushed[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: registered head byte, pointers cleared by the shared reset.
  logic [7:0] mem [NL][16];
  int wr_ptr [NL];
  int rd_ptr [NL];

  always_comb begin
    for (int l = 0; l < NL; l++) fifo_empty[l] = (wr_ptr[l] == rd_ptr[l]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        rd_ptr[l]         <= 0;
        fifo_read_data[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        fifo_read_data[l] <= mem[l][rd_ptr[l] % 16];
        if (fifo_read_strobe[l] && !fifo_empty[l]) rd_ptr[l] <= rd_ptr[l] + 1;
      end
    end
  end

  // Transmitter models: ready drops the cycle after tx_start, returns after tx_time cycles.
  int tx_time [NL];
  int tx_cnt  [NL];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        tx_ready[l] <= 1'b1;
        tx_cnt[l]   <= 0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (tx_start[l]) begin
          tx_ready[l] <= 1'b0;
          tx_cnt[l]   <= tx_time[l];
        end else if (!tx_ready[l]) begin
          if (tx_cnt[l] <= 1) tx_ready[l] <= 1'b1;
          else                tx_cnt[l]   <= tx_cnt[l] - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors sample on the falling edge.
  logic [7:0] exp_q [$];
  int st_q0 [$];
  int st_q1 [$];
  int rq0 [$];
  int rq1 [$];
  int strobe_cnt [NL] = '{0, 0};
  int start_cnt  [NL] = '{0, 0};
  int under_cnt  [NL] = '{0, 0};
  int last_start [NL] = '{0, 0};
  logic [NL-1:0] prev_ready = '1;

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (fifo_read_strobe[l]) begin
        strobe_cnt[l]++;
        if (fifo_empty[l]) under_cnt[l]++;
        if (l == 0) st_q0.push_back(cyc);
        else        st_q1.push_back(cyc);
      end
      if (tx_ready[l] && !prev_ready[l]) begin
        if (l == 0) rq0.push_back(cyc);
        else        rq1.push_back(cyc);
      end
      prev_ready[l] = tx_ready[l];
      if (tx_start[l]) begin
        start_cnt[l]++;
        last_start[l] = cyc;
      end
    end
    if (tx_start[0]) begin
      check("sb_expected_present", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_tx_byte", 64'(tx_byte[0]), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int l, input logic [7:0] d, input bit expect_send);
    mem[l][wr_ptr[l] % 16] = d;
    wr_ptr[l] = wr_ptr[l] + 1;
    if (expect_send) exp_q.push_back(d);
  endtask

  task automatic wait_starts(input int l, input int n, input int budget, input string tag);
    int k = 0;
    while ((start_cnt[l] < n || busy[l]) && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_in_time"}, 64'(k < budget), 64'd1);
  endtask

  task automatic wait_strobe(input int l, input int budget, input string tag);
    int k = 0;
    while (!fifo_read_strobe[l] && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_in_time"}, 64'(k < budget), 64'd1);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    for (int l = 0; l < NL; l++) wr_ptr[l] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bs, bt;
    flush = 1'b0;
    cts_n = 1'b0;
    enable = '0;
    tx_time[0] = 10;
    tx_time[1] = 1;
    hard_reset();
    repeat (3) tick();
    check("rst_strobe", 64'(fifo_read_strobe[0]), 64'd0);
    check("rst_tx_start", 64'(tx_start[0]), 64'd0);
    check("rst_tx_byte", 64'(tx_byte[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_bytes_sent", 64'(bytes_sent[0]), 64'd0);
    check("rst_bytes_flushed", 64'(bytes_flushed[0]), 64'd0);
    rst = 1'b0;
    tick();

    // Three bytes through a 10-cycle transmitter.
    st_q0.delete();
    rq0.delete();
    bs = strobe_cnt[0];
    enable[0] = 1'b1;
    push(0, 8'h41, 1'b1);
    push(0, 8'h42, 1'b1);
    push(0, 8'h43, 1'b1);
    wait_starts(0, 3, 300, "t1");
    check("t1_strobes", 64'(strobe_cnt[0] - bs), 64'd3);
    check("t1_bytes_sent", 64'(bytes_sent[0]), 64'd3);
    check("t1_fifo_empty", 64'(fifo_empty[0]), 64'd1);
    check("t1_busy", 64'(busy[0]), 64'd0);
    check("t1_strobe_spacing", 64'(st_q0[1] - st_q0[0]), 64'(5 + tx_time[0]));
    check("t1_spacing2", 64'(st_q0[2] - st_q0[1]), 64'(5 + tx_time[0]));
    check("t1_ready_to_strobe", 64'(st_q0[1] - rq0[0]), 64'd3);

    // Single byte latency from the cycle the start condition is sampled.
    st_q0.delete();
    tick();
    k = cyc;
    push(0, 8'h55, 1'b1);
    wait_starts(0, 4, 100, "t2");
    check("t2_strobe_latency", 64'(st_q0[0] - k), 64'd2);
    check("t2_start_latency", 64'(last_start[0] - k), 64'd3);
    check("t2_tx_byte", 64'(tx_byte[0]), 64'h55);

    // Inter-byte gap of 4 on the second instance.
    st_q1.delete();
    rq1.delete();
    enable[1] = 1'b1;
    push(1, 8'hA0, 1'b0);
    push(1, 8'hA1, 1'b0);
    wait_starts(1, 2, 200, "gap");
    check("gap_strobe_spacing", 64'(st_q1[1] - st_q1[0]), 64'(5 + tx_time[1] + 4));
    check("gap_ready_to_strobe", 64'(st_q1[1] - rq1[0]), 64'd7);
    check("gap_tx_byte", 64'(tx_byte[1]), 64'hA1);
    check("gap_bytes_sent", 64'(bytes_sent[1]), 64'd2);

    // CTS holds off, then releases, then holds the second byte.
    cts_n = 1'b1;
    bs = strobe_cnt[0];
    bt = start_cnt[0];
    push(0, 8'h61, 1'b1);
    push(0, 8'h62, 1'b1);
    repeat (50) tick();
    check("cts_no_strobe", 64'(strobe_cnt[0] - bs), 64'd0);
    check("cts_no_start", 64'(start_cnt[0] - bt), 64'd0);
    cts_n = 1'b0;
    k = 0;
    while (start_cnt[0] < bt + 1 && k < 50) begin
      tick();
      k++;
    end
    check("cts_first_in_time", 64'(k < 50), 64'd1);
    cts_n = 1'b1;
    repeat (40) tick();
    check("cts_held_starts", 64'(start_cnt[0] - bt), 64'd1);
    check("cts_held_busy", 64'(busy[0]), 64'd0);
    check("cts_held_fifo", 64'(fifo_empty[0]), 64'd0);
    cts_n = 1'b0;
    wait_starts(0, bt + 2, 100, "cts_second");
    check("cts_fifo_empty", 64'(fifo_empty[0]), 64'd1);

    // Flush while byte 0 is in flight.
    st_q0.delete();
    bt = start_cnt[0];
    push(0, 8'hB0, 1'b1);
    for (int i = 1; i < 5; i++) push(0, 8'(8'hB0 + i), 1'b0);
    k = 0;
    while (start_cnt[0] < bt + 1 && k < 50) begin
      tick();
      k++;
    end
    check("flush_byte0_in_time", 64'(k < 50), 64'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while ((busy[0] || !fifo_empty[0]) && k < 200) begin
      tick();
      k++;
    end
    check("flush_done_in_time", 64'(k < 200), 64'd1);
    check("flush_starts", 64'(start_cnt[0] - bt), 64'd1);
    check("flush_strobe_total", 64'(st_q0.size()), 64'd5);
    for (int i = 2; i < 5; i++) check("flush_spacing", 64'(st_q0[i] - st_q0[i-1]), 64'd3);
    check("flush_bytes_flushed", 64'(bytes_flushed[0]), 64'd4);
    check("flush_underflow", 64'(under_cnt[0]), 64'd0);
    check("flush_busy", 64'(busy[0]), 64'd0);

    // Reset during LOAD.
    push(0, 8'hC0, 1'b0);
    wait_strobe(0, 20, "rst_load");
    hard_reset();
    #1;
    check("rl_strobe", 64'(fifo_read_strobe[0]), 64'd0);
    check("rl_tx_start", 64'(tx_start[0]), 64'd0);
    check("rl_tx_byte", 64'(tx_byte[0]), 64'd0);
    check("rl_busy", 64'(busy[0]), 64'd0);
    check("rl_bytes_sent", 64'(bytes_sent[0]), 64'd0);
    bs = strobe_cnt[0];
    bt = start_cnt[0];
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rl_no_strobe", 64'(strobe_cnt[0] - bs), 64'd0);
    check("rl_no_start", 64'(start_cnt[0] - bt), 64'd0);

    // Reset during FLUSH_RD.
    enable[0] = 1'b0;
    push(0, 8'hD0, 1'b0);
    push(0, 8'hD1, 1'b0);
    push(0, 8'hD2, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_strobe(0, 20, "rst_flush");
    hard_reset();
    #1;
    check("rf_strobe", 64'(fifo_read_strobe[0]), 64'd0);
    check("rf_busy", 64'(busy[0]), 64'd0);
    check("rf_bytes_flushed", 64'(bytes_flushed[0]), 64'd0);
    bs = strobe_cnt[0];
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rf_no_strobe", 64'(strobe_cnt[0] - bs), 64'd0);

    // Counter wrap.
    enable[0] = 1'b1;
    tick();
    force dut0.bytes_sent = 32'hFFFF_FFFF;
    tick();
    release dut0.bytes_sent;
    bt = start_cnt[0];
    push(0, 8'h5A, 1'b1);
    wait_starts(0, bt + 1, 100, "wrap");
    check("wrap_bytes_sent", 64'(bytes_sent[0]), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("no_underflow", 64'(under_cnt[0] + under_cnt[1]), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
